pipe_stage_skid: RTL

- Parametrised successor of the fixed-field inter-stage pipeline registers, e.g. EX->MEM.
- Carries an opaque DATA_W-bit payload through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Keeps the ctrl-driven hold (stall) and clear (flush) controls of the earlier stage registers.
- Adds backpressure absorption without a combinational ready path, plus a saturating stall counter for ctrl/debug.

---
 rtl/pipe_stage_skid.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, ctrl hold/clear,
// and a saturating backpressure counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no payload stored (main_v=0, skid_v=0)
// S_ONE   | payload in main register only (main_v=1, skid_v=0)
// S_FULL  | main and skid registers both hold payloads (main_v=1, skid_v=1)
module pipe_stage_skid #(
    parameter int unsigned          DATA_W    = 32,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk_100M,
    input  logic              arst_n,
    input  logic              clear,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic main_v;
    logic skid_v;
    logic in_fire;
    logic out_fire;

    // Handshake outputs derive only from registered state and ctrl inputs.
    always_comb begin
        main_v    = (state_q != S_EMPTY);
        skid_v    = (state_q == S_FULL);
        in_ready  = ~skid_v & ~hold & ~clear;
        out_valid = main_v & ~hold;
        out_data  = main_data_q;
        occupancy = {1'b0, main_v} + {1'b0, skid_v};
        stall_cnt = stall_cnt_q;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
    end

    // Next-state and datapath: clear beats hold beats normal flow.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        stall_cnt_d = stall_cnt_q;

        if (clear) begin
            state_d     = S_EMPTY;
            main_data_d = RESET_VAL;
            skid_data_d = RESET_VAL;
        end else if (!hold) begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d     = S_ONE;
                        main_data_d = in_data;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        state_d     = S_FULL;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        // main_data keeps its stale value; only the valid drops.
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_d     = S_ONE;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase

            if (main_v && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk_100M) begin
        if (!arst_n) begin
            state_q     <= S_EMPTY;
            main_data_q <= RESET_VAL;
            skid_data_q <= RESET_VAL;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
